dmem_responder: RTL and testbench

//  Memory-side responder for the simd_processor data-memory port (M stage).
//  src_sel=0: local scratch RAM, combinational read, write on clock edge.
//  src_sel=1: memory-mapped posted-write queue drained to an external sink over valid/ready.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the M stage and the responder, plus the
// external posted-write sink handshake.
interface dmem_responder_if;
   logic        memwriteM;
   logic        src_sel;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic [31:0] readdataM;
   logic        ext_valid;
   logic        ext_ready;
   logic [31:0] ext_addr;
   logic [31:0] ext_data;

   // Processor / sink side
   modport master (
      output memwriteM, src_sel, aluoutM, writedataM, ext_ready,
      input  readdataM, ext_valid, ext_addr, ext_data
   );

   // Responder side
   modport slave (
      input  memwriteM, src_sel, aluoutM, writedataM, ext_ready,
      output readdataM, ext_valid, ext_addr, ext_data
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: local scratch RAM (src_sel=0) and a memory-mapped
// posted-write queue drained over valid/ready (src_sel=1, reads give status).
module dmem_responder #(
   parameter int unsigned RAM_AW  = 8,
   parameter int unsigned FIFO_AW = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned RamWords  = 2 ** RAM_AW;
   localparam int unsigned FifoDepth = 2 ** FIFO_AW;

   logic [31:0]        ram      [RamWords];
   logic [31:0]        q_addr   [FifoDepth];
   logic [31:0]        q_data   [FifoDepth];

   logic [FIFO_AW:0]   wr_ptr;
   logic [FIFO_AW:0]   rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               overflow;
   logic [7:0]         drop_cnt;

   logic [RAM_AW-1:0]  ram_idx;
   logic               empty;
   logic               full;
   logic               push_req;
   logic               clr_req;
   logic               pop;
   logic               push_ok;
   logic               drop;
   logic [31:0]        status;

   assign ram_idx = bus.aluoutM[RAM_AW+1:2];

   // Queue occupancy and handshake decode; the wrap bit separates full from empty
   always_comb begin
      count    = wr_ptr - rd_ptr;
      empty    = (wr_ptr == rd_ptr);
      full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
      push_req = bus.memwriteM && bus.src_sel && !bus.aluoutM[31];
      clr_req  = bus.memwriteM && bus.src_sel && bus.aluoutM[31];
      pop      = !empty && bus.ext_ready;
      // A pop in the same cycle frees the slot, so a full queue still accepts
      push_ok  = push_req && (!full || pop);
      drop     = push_req && full && !pop;
   end

   // Scratch RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (!reset && bus.memwriteM && !bus.src_sel) begin
         ram[ram_idx] <= bus.writedataM;
      end
   end

   // Queue entry storage; only pointers are reset, stale entries are masked by empty
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         q_addr[wr_ptr[FIFO_AW-1:0]] <= bus.aluoutM;
         q_data[wr_ptr[FIFO_AW-1:0]] <= bus.writedataM;
      end
   end

   // Pointers, sticky overflow and saturating drop counter
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (clr_req) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   // Head presentation straight from storage, zeroed when empty
   always_comb begin
      bus.ext_valid = !empty;
      bus.ext_addr  = empty ? 32'd0 : q_addr[rd_ptr[FIFO_AW-1:0]];
      bus.ext_data  = empty ? 32'd0 : q_data[rd_ptr[FIFO_AW-1:0]];
   end

   // Status word assembly and load-data mux
   always_comb begin
      status              = '0;
      status[31]          = overflow;
      status[30]          = full;
      status[29]          = empty;
      status[23:16]       = drop_cnt;
      status[FIFO_AW:0]   = count;
      if (reset) begin
         bus.readdataM = 32'd0;
      end else if (bus.src_sel) begin
         bus.readdataM = status;
      end else begin
         bus.readdataM = ram[ram_idx];
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } entry_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(
      .RAM_AW  (8),
      .FIFO_AW (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_ram    [256];
   bit          m_ram_ok [256];
   entry_t      mq[$];
   bit          m_ovf;
   int          m_drop;
   bit          m_known;

   logic [31:0] last_rd;
   logic [31:0] last_data;
   logic        last_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 32'd0;
      s[31]    = m_ovf;
      s[30]    = (mq.size() == 4);
      s[29]    = (mq.size() == 0);
      s[23:16] = m_drop[7:0];
      s[2:0]   = mq.size();
      return s;
   endfunction

   // One clock of stimulus: drive at negedge, check pre-edge outputs, update model at posedge
   task automatic cycle(input bit rst, input bit we, input bit sel,
                        input logic [31:0] addr, input logic [31:0] data, input bit rdy);
      int          idx;
      int          sz;
      bit          popd;
      logic [31:0] exp_a;
      logic [31:0] exp_d;
      idx = int'((addr >> 2) % 256);
      @(negedge clk);
      reset          = rst;
      bus.memwriteM  = we;
      bus.src_sel    = sel;
      bus.aluoutM    = addr;
      bus.writedataM = data;
      bus.ext_ready  = rdy;
      #1;
      last_rd    = bus.readdataM;
      last_data  = bus.ext_data;
      last_valid = bus.ext_valid;
      if (m_known) begin
         exp_a = (mq.size() > 0) ? mq[0].a : 32'd0;
         exp_d = (mq.size() > 0) ? mq[0].d : 32'd0;
         check("ext_valid", {31'd0, bus.ext_valid}, {31'd0, mq.size() > 0});
         check("ext_addr", bus.ext_addr, exp_a);
         check("ext_data", bus.ext_data, exp_d);
      end
      if (rst) begin
         check("rd_in_reset", bus.readdataM, 32'd0);
      end else if (!we && m_known) begin
         if (sel) check("status", bus.readdataM, m_status());
         else if (m_ram_ok[idx]) check("ram_rd", bus.readdataM, m_ram[idx]);
      end
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_drop  = 0;
         m_known = 1'b1;
      end else begin
         sz   = mq.size();
         popd = (sz > 0) && rdy;
         if (we && !sel) begin
            m_ram[idx]    = data;
            m_ram_ok[idx] = 1'b1;
         end
         if (popd) void'(mq.pop_front());
         if (we && sel) begin
            if (addr[31]) begin
               m_ovf  = 1'b0;
               m_drop = 0;
            end else if (sz < 4 || popd) begin
               mq.push_back('{a: addr, d: data});
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 255) m_drop++;
            end
         end
      end
   endtask

   initial begin
      logic [31:0] a;
      bit we;
      bit sel;
      bit rdy;
      bit rst;
      m_known = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = 0;
      for (int i = 0; i < 256; i++) m_ram_ok[i] = 1'b0;

      // Reset
      cycle(1, 0, 1, 32'h0, 32'h0, 0);
      cycle(1, 0, 0, 32'h0, 32'h0, 0);
      cycle(0, 0, 1, 32'h0, 32'h0, 0);
      check("reset_status", last_rd, 32'h2000_0000);

      // RAM write/read and sub-word address bits
      cycle(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 0);
      cycle(0, 0, 0, 32'h10, 32'h0, 0);
      check("ram_0x10", last_rd, 32'hDEAD_BEEF);
      cycle(0, 0, 0, 32'h11, 32'h0, 0);
      check("ram_0x11", last_rd, 32'hDEAD_BEEF);

      // Aliasing of upper address bits
      cycle(0, 1, 0, 32'h000, 32'h1, 0);
      cycle(0, 0, 0, 32'h400, 32'h0, 0);
      check("ram_alias", last_rd, 32'h1);

      // Three pushes held, then drained in order
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 32'h100 + 4 * i, 32'hA0 + i, 0);
      cycle(0, 0, 1, 32'h0, 32'h0, 0);
      check("count3", last_rd, 32'h0000_0003);
      check("valid3", {31'd0, last_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 32'h0, 32'h0, 1);
         check("drain_order", last_data, 32'hA0 + i);
      end
      cycle(0, 0, 1, 32'h0, 32'h0, 0);
      check("drained", last_rd, 32'h2000_0000);

      // Overflow and clear
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 32'h200 + 4 * i, 32'hB0 + i, 0);
      cycle(0, 0, 1, 32'h0, 32'h0, 0);
      check("overflow", last_rd, 32'hC002_0004);
      cycle(0, 1, 1, 32'h8000_0000, 32'h0, 0);
      cycle(0, 0, 1, 32'h0, 32'h0, 0);
      check("cleared", last_rd, 32'h4000_0004);

      // Push and pop together while full
      cycle(0, 1, 1, 32'h300, 32'hCAFE, 1);
      cycle(0, 0, 1, 32'h0, 32'h0, 0);
      check("full_pp", last_rd, 32'h4000_0004);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h0, 32'h0, 1);
      check("new_last", last_data, 32'hCAFE);

      // Reset mid-drain
      cycle(0, 1, 1, 32'h400, 32'hD0, 0);
      cycle(0, 1, 1, 32'h404, 32'hD1, 0);
      cycle(1, 1, 1, 32'h408, 32'hD2, 0);
      cycle(0, 0, 1, 32'h0, 32'h0, 0);
      check("rst_valid", {31'd0, last_valid}, 32'd0);
      check("rst_status", last_rd, 32'h2000_0000);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         we  = $urandom_range(0, 1);
         sel = $urandom_range(0, 1);
         rdy = ($urandom_range(0, 2) == 0);
         a   = $urandom & 32'h7FFF_FC3F;
         if (sel && we && $urandom_range(0, 9) == 0) a[31] = 1'b1;
         cycle(rst, we, sel, a, $urandom, rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
